// File: rtl/hp_vpu_lut_pkg.sv
// Shared types and constants for the VPU LUT path (sequencer and ROM).
package hp_vpu_lut_pkg;

  // ROM index and result widths, common to hp_vpu_lut_seq and hp_vpu_lut_rom
  localparam int LUT_IDX_W = 8;
  localparam int LUT_RES_W = 16;

  // LUT function codes carried on func_sel
  typedef enum logic [1:0] {
    LUT_EXP     = 2'd0,
    LUT_RECIP   = 2'd1,
    LUT_SIGMOID = 2'd2,
    LUT_TANH    = 2'd3
  } lut_func_e;

  // Sequencer states; ST_DRAIN is only visited with the result pipeline stage
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } lut_seq_state_e;

endpackage

// File: rtl/hp_vpu_lut_rom.sv
// Combinational LUT ROM stand-in: result = {6'b0, func_sel, index}.
// Function 0 is therefore the identity table {8'h00, index}; the other
// functions tag the upper byte with the function code so that the selected
// function is visible in every result.
module hp_vpu_lut_rom
  import hp_vpu_lut_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] index_i,
  input  logic [1:0]           func_sel_i,
  output logic [LUT_RES_W-1:0] result_o
);

  // Table lookup, purely combinational
  always_comb begin
    result_o = {6'b00_0000, func_sel_i, index_i};
  end

endmodule

// File: rtl/hp_vpu_lut_seq.sv
// hp_vpu_lut_seq: steps a vector of NLANES 8-bit elements through the LUT ROM
// one element per cycle and returns the gathered 16-bit results over a
// valid/ready handshake.
// Optional macro HP_VPU_LUT_PIPE_EN: registers lut_result_i (together with its
// lane index and mask bit) for a ROM with a one-cycle read; adds a DRAIN state.
module hp_vpu_lut_seq
  import hp_vpu_lut_pkg::*;
#(
  parameter int NLANES = 8,
  parameter int ID_W   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [NLANES*8-1:0]         req_data_i,
  input  logic [1:0]                  req_func_i,
  input  logic [NLANES-1:0]           req_mask_i,
  input  logic [ID_W-1:0]             req_id_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [NLANES*LUT_RES_W-1:0] rsp_data_o,
  output logic [ID_W-1:0]             rsp_id_o,
  output logic [LUT_IDX_W-1:0]        lut_index_o,
  output logic [1:0]                  lut_func_o,
  input  logic [LUT_RES_W-1:0]        lut_result_i,
  output logic                        busy_o
);

  localparam int                CNT_W    = $clog2(NLANES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NLANES - 1);

  lut_seq_state_e                  state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NLANES*8-1:0]             data_q, data_d;
  lut_func_e                       func_q, func_d;
  logic [NLANES-1:0]               mask_q, mask_d;
  logic [ID_W-1:0]                 id_q, id_d;
  logic [NLANES*LUT_RES_W-1:0]     res_q, res_d;
  // Registered request-ready: low during reset, high only while IDLE
  logic                            ready_q, ready_d;

`ifdef HP_VPU_LUT_PIPE_EN
  // Result pipeline stage: valid, lane index, mask bit and ROM data
  logic                            pv_q, pv_d;
  logic [CNT_W-1:0]                plane_q, plane_d;
  logic                            pmask_q, pmask_d;
  logic [LUT_RES_W-1:0]            pres_q, pres_d;
`endif

  // Next-state, datapath and ROM-interface decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    func_d      = func_q;
    mask_d      = mask_q;
    id_d        = id_q;
    res_d       = res_q;
    lut_index_o = {LUT_IDX_W{1'b0}};
    lut_func_o  = 2'b00;

`ifdef HP_VPU_LUT_PIPE_EN
    pv_d    = 1'b0;
    plane_d = cnt_q;
    pmask_d = 1'b0;
    pres_d  = lut_result_i;
    // Capture the result issued on the previous cycle
    if (pv_q) begin
      if (pmask_q) begin
        res_d[32'(plane_q)*32'd16 +: LUT_RES_W] = pres_q;
      end else begin
        res_d[32'(plane_q)*32'd16 +: LUT_RES_W] = {LUT_RES_W{1'b0}};
      end
    end else begin
      res_d = res_q;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          data_d  = req_data_i;
          func_d  = lut_func_e'(req_func_i);
          mask_d  = req_mask_i;
          id_d    = req_id_i;
          res_d   = {(NLANES*LUT_RES_W){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        lut_index_o = data_q[32'(cnt_q)*32'd8 +: LUT_IDX_W];
        lut_func_o  = func_q;
`ifdef HP_VPU_LUT_PIPE_EN
        pv_d    = 1'b1;
        plane_d = cnt_q;
        pmask_d = mask_q[cnt_q];
`else
        if (mask_q[cnt_q]) begin
          res_d[32'(cnt_q)*32'd16 +: LUT_RES_W] = lut_result_i;
        end else begin
          res_d[32'(cnt_q)*32'd16 +: LUT_RES_W] = {LUT_RES_W{1'b0}};
        end
`endif
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
`ifdef HP_VPU_LUT_PIPE_EN
          state_d = ST_DRAIN;
`else
          state_d = ST_RESP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        // Last lane is captured by the pipeline logic above this cycle
`ifdef HP_VPU_LUT_PIPE_EN
        state_d = ST_RESP;
`else
        state_d = ST_IDLE;
`endif
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; reset aborts any request in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      data_q  <= {(NLANES*8){1'b0}};
      func_q  <= LUT_EXP;
      mask_q  <= {NLANES{1'b0}};
      id_q    <= {ID_W{1'b0}};
      res_q   <= {(NLANES*LUT_RES_W){1'b0}};
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      func_q  <= func_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      res_q   <= res_d;
      ready_q <= ready_d;
    end
  end

`ifdef HP_VPU_LUT_PIPE_EN
  // Result pipeline register for the one-cycle ROM read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q    <= 1'b0;
      plane_q <= {CNT_W{1'b0}};
      pmask_q <= 1'b0;
      pres_q  <= {LUT_RES_W{1'b0}};
    end else begin
      pv_q    <= pv_d;
      plane_q <= plane_d;
      pmask_q <= pmask_d;
      pres_q  <= pres_d;
    end
  end
`endif

  assign req_ready_o = ready_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_data_o  = res_q;
  assign rsp_id_o    = id_q;

endmodule

// File: tb/tb_hp_vpu_lut_seq.sv
// Scoreboard bench for hp_vpu_lut_seq driving the hp_vpu_lut_rom stand-in.
module tb_hp_vpu_lut_seq;

  localparam int NLANES = 8;
  localparam int ID_W   = 4;
`ifdef HP_VPU_LUT_PIPE_EN
  localparam int LAT = NLANES + 2;
`else
  localparam int LAT = NLANES + 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic [NLANES*8-1:0]  req_data;
  logic [1:0]           req_func;
  logic [NLANES-1:0]    req_mask;
  logic [ID_W-1:0]      req_id;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [NLANES*16-1:0] rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           lut_index;
  logic [1:0]           lut_func;
  logic [15:0]          lut_result;
  logic                 busy;

  always #5 clk = ~clk;

  hp_vpu_lut_seq #(.NLANES(NLANES), .ID_W(ID_W)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_i(req_data), .req_func_i(req_func),
    .req_mask_i(req_mask), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
    .lut_index_o(lut_index), .lut_func_o(lut_func),
    .lut_result_i(lut_result), .busy_o(busy)
  );

  hp_vpu_lut_rom u_rom (
    .index_i(lut_index), .func_sel_i(lut_func), .result_o(lut_result)
  );

  typedef struct {
    logic [ID_W-1:0]      id;
    logic [NLANES*16-1:0] data;
    int                   acc;
  } exp_t;

  exp_t           sb_q[$];
  int             checks   = 0;
  int             failures = 0;
  int             cyc      = 0;
  bit             cur_active = 1'b0;
  int             cur_acc    = 0;
  logic [63:0]    cur_data   = 64'h0;
  logic [1:0]     cur_func   = 2'b00;
  bit             in_rsp     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Expected response for the ROM stand-in: masked lanes are zero
  function automatic logic [127:0] exp_vec(input logic [63:0] d, input logic [1:0] f,
                                           input logic [7:0] m);
    logic [127:0] r;
    r = 128'h0;
    for (int k = 0; k < NLANES; k++)
      if (m[k]) r[k*16 +: 16] = {6'b00_0000, f, d[k*8 +: 8]};
    return r;
  endfunction

  // Monitor: ROM interface per cycle, response against scoreboard head
  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp = 1'b0;
    end else begin
      if (cur_active && cyc >= cur_acc + 1 && cyc <= cur_acc + NLANES) begin
        chk("run_func", 128'(lut_func), 128'(cur_func));
        chk("run_index", 128'(lut_index), 128'(cur_data[(cyc - cur_acc - 1)*8 +: 8]));
      end else begin
        chk("idle_index", 128'(lut_index), 128'h0);
        chk("idle_func", 128'(lut_func), 128'h0);
      end
      if (rsp_valid) begin
        chk("req_ready_in_resp", 128'(req_ready), 128'h0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=valid id=%h required=no response", rsp_id);
        end else begin
          if (!in_rsp) begin
            in_rsp = 1'b1;
            chk("latency", 128'(cyc - sb_q[0].acc), 128'(LAT));
          end
          chk("rsp_data", rsp_data, sb_q[0].data);
          chk("rsp_id", 128'(rsp_id), 128'(sb_q[0].id));
          if (rsp_ready) begin
            void'(sb_q.pop_front());
            in_rsp = 1'b0;
          end
        end
      end
    end
  end

  // Offer one request, wait (bounded) for acceptance, push its expectation
  task automatic issue(input logic [ID_W-1:0] id, input logic [63:0] d, input logic [1:0] f,
                       input logic [7:0] m, input logic [127:0] expd, output int acc);
    @(posedge clk); #1;
    req_valid = 1'b1; req_data = d; req_func = f; req_mask = m; req_id = id;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not accepted required=accepted id=%h", id);
    end else begin
      sb_q.push_back('{id, expd, acc});
      cur_acc = acc; cur_data = d; cur_func = f; cur_active = 1'b1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int a0, a1, hs;
    int accs[4];
    logic [63:0] bd;

    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_func = 2'b00;
    req_mask = '0; req_id = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 128'(rsp_valid), 128'h0);
    chk("rst_rsp_data", rsp_data, 128'h0);
    chk("rst_rsp_id", 128'(rsp_id), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_lut_index", 128'(lut_index), 128'h0);
    chk("rst_lut_func", 128'(lut_func), 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 128'(req_ready), 128'h1);

    // Identity: lane k = k, func 0, all lanes enabled
    issue(4'd3, 64'h0706050403020100, 2'd0, 8'hFF,
          128'h0007_0006_0005_0004_0003_0002_0001_0000, a0);
    drain();

    // Masking: odd lanes only
    issue(4'd5, 64'h5A5A5A5A5A5A5A5A, 2'd0, 8'hAA,
          128'h005A_0000_005A_0000_005A_0000_005A_0000, a0);
    drain();

    // All-zero mask: zero response, same latency
    issue(4'd6, 64'hFFEEDDCCBBAA9988, 2'd1, 8'h00, 128'h0, a0);
    drain();

    // Function sampled at acceptance; input toggles during RUN are ignored
    issue(4'd7, 64'h8877665544332211, 2'd2, 8'hFF,
          128'h0288_0277_0266_0255_0244_0233_0222_0211, a0);
    for (int i = 0; i < NLANES; i++) begin
      req_func = req_func ^ 2'b11;
      req_data = ~req_data;
      @(posedge clk); #1;
    end
    drain();

    // Backpressure: hold the response 20 cycles while a second request waits
    rsp_ready = 1'b0;
    issue(4'd9, 64'h1122334455667788, 2'd1, 8'h0F,
          128'h0000_0000_0000_0000_0155_0166_0177_0188, a0);
    hs = -1;
    fork
      issue(4'd10, 64'hF0E0D0C0B0A09080, 2'd3, 8'hFF,
            128'h03F0_03E0_03D0_03C0_03B0_03A0_0390_0380, a1);
      begin
        for (int i = 0; i < 50; i++) begin
          if (rsp_valid) break;
          @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        hs = cyc;
      end
    join
    chk("second_accept_after_hs", 128'(a1), 128'(hs + 1));
    drain();

    // Reset in the 4th RUN cycle aborts the request
    issue(4'd12, 64'h0102030405060708, 2'd0, 8'hFF, 128'h0, a0);
    while (cyc < a0 + 4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    cur_active = 1'b0;
    chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'h0);
    chk("mid_rst_req_ready", 128'(req_ready), 128'h0);
    chk("mid_rst_busy", 128'(busy), 128'h0);
    chk("mid_rst_lut_index", 128'(lut_index), 128'h0);
    chk("mid_rst_lut_func", 128'(lut_func), 128'h0);
    chk("mid_rst_rsp_data", rsp_data, 128'h0);
    chk("mid_rst_rsp_id", 128'(rsp_id), 128'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    issue(4'd13, 64'h0706050403020100, 2'd0, 8'hFF,
          128'h0007_0006_0005_0004_0003_0002_0001_0000, a0);
    drain();

    // Back-to-back requests with the consumer always ready
    for (int r = 0; r < 4; r++) begin
      bd = {8{8'(8'h10 * r + 8'h03)}} ^ 64'h0011_2233_4455_6677;
      issue(4'(r + 1), bd, 2'(r), 8'hFF >> r, exp_vec(bd, 2'(r), 8'hFF >> r), accs[r]);
    end
    drain();
    for (int r = 1; r < 4; r++)
      chk("b2b_spacing", 128'(accs[r] - accs[r-1]), 128'(LAT + 1));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hp_vpu_lut_seq.md
Name: hp_vpu_lut_seq

Overview:
- Sequencer directly upstream of the VPU LUT ROM (hp_vpu_lut_rom).
- Accepts one vector request of NLANES 8-bit elements plus a function select, and steps each element through the ROM's index/func_sel inputs, one element per cycle.
- Gathers the 16-bit ROM results into a packed response vector returned over a valid/ready handshake.
- Sits between VPU issue/dispatch and the writeback path for LUT-class ops (exp, recip, sigmoid, etc.).

Parameters:
- NLANES, 8, elements per vector request (power of two, 2..32)
- ID_W, 4, width of the request tag passed through to the response

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  request valid
- req_ready_o  output  1  sequencer can accept a request
- req_data_i  input  NLANES*8  element k at bits [8k+7:8k]
- req_func_i  input  2  LUT function select
- req_mask_i  input  NLANES  lane enable; 0 = lane result forced to zero
- req_id_i  input  ID_W  request tag
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  consumer accepts response
- rsp_data_o  output  NLANES*16  lane k result at bits [16k+15:16k]
- rsp_id_o  output  ID_W  tag of the completed request
- lut_index_o  output  8  to ROM index_i
- lut_func_o  output  2  to ROM func_sel_i
- lut_result_i  input  16  from ROM result_o (combinational)
- busy_o  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert upstream):
  - state=IDLE; rsp_valid_o=0; rsp_data_o=0; rsp_id_o=0.
  - lut_index_o=0; lut_func_o=0; busy_o=0; req_ready_o=1 once out of reset.
- FSM states: IDLE, RUN, DRAIN (only with the optional feature), RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o: latch data, func, mask, id; clear the result buffer; lane counter=0; go to RUN.
- RUN:
  - Each cycle drive lut_index_o=element[cnt] and lut_func_o=latched func.
  - Capture lut_result_i into result lane cnt the same cycle, or 16'h0000 if mask[cnt]=0.
  - cnt increments; when cnt==NLANES-1 → RESP (→ DRAIN with the optional feature).
  - cnt width is $clog2(NLANES); it never wraps within a request.
- RESP:
  - rsp_valid_o=1; rsp_data_o and rsp_id_o stable while rsp_valid_o && !rsp_ready_i.
  - On rsp_ready_i → IDLE.
  - The response is held indefinitely under backpressure.
- req_ready_o=0 in every state except IDLE. There is no overlap of requests; a request arriving during RESP is stalled until the cycle after the response handshake.
- lut_index_o/lut_func_o are 0 outside RUN. The ROM is never read with stale data.
- Latency:
  - Request handshake at cycle 0; RUN occupies cycles 1..NLANES; rsp_valid_o rises at cycle NLANES+1.
  - Throughput is one request per NLANES+2 cycles at best.
- Mask: masked lanes still consume their RUN cycle (fixed latency, mask-independent). An all-zero mask gives an all-zero response with the same latency.
- Reset mid-operation: immediately aborts; no response is emitted; the latched request is discarded.
- Function select is sampled once at acceptance; later changes on req_func_i are ignored.

Optional Feature:
- Macro HP_VPU_LUT_PIPE_EN.
- Defined:
  - A register stage sits on lut_result_i (for a BRAM-style 1-cycle ROM read); lane index and mask bit are pipelined alongside it.
  - Capture occurs one cycle after issue.
  - RUN → DRAIN (1 cycle, captures the last lane) → RESP; rsp_valid_o rises at cycle NLANES+2.
- Undefined: combinational capture as described above, with no DRAIN state.

Decomposition:
- Package hp_vpu_lut_pkg:
  - lut_func_e enum (2-bit function codes).
  - lut_seq_state_e enum.
  - Constants LUT_IDX_W=8 and LUT_RES_W=16, shared with hp_vpu_lut_rom.
- No sub-module needed. The optional result pipeline register lives inline under the macro.
- The testbench instantiates hp_vpu_lut_seq plus hp_vpu_lut_rom.

Test Plan:
- Basic identity: with the identity ROM model (result={8'h00,index}), NLANES=8, data=0x07..0x00 (lane k=k), func=0, mask=0xFF, id=3 → rsp_valid_o at cycle 9 (10 with PIPE_EN); rsp_data lane k=0x000k; rsp_id_o=3.
- Masking: mask=0xAA, all lanes data=0x5A → even lanes 0x0000, odd lanes 0x005A; latency unchanged.
- Backpressure: hold rsp_ready_i=0 for 20 cycles → rsp_data_o/rsp_id_o stable and req_ready_o=0 throughout. A second request offered meanwhile is accepted only the cycle after rsp_ready_i=1.
- Func sampling: func=2 at acceptance, req_func_i toggles during RUN → lut_func_o=2 on every RUN cycle; lut_index_o=0 and lut_func_o=0 in IDLE/RESP.
- Reset mid-RUN: assert rst_ni=0 at cycle 4 of RUN → all outputs zero asynchronously; no rsp_valid_o after release; the next request completes normally.
- Back-to-back: 4 consecutive requests with rsp_ready_i=1 → each completes in NLANES+2 cycles (+1 with PIPE_EN), with ids in order and no lane corruption.
